// File: rtl/inst_enc_pkg.sv
// Shared types for the RV64I instruction encoder: format codes, major opcodes, request struct.
// Also holds the immediate sign-extension range helper used by the packer.
package inst_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Major opcode groups, inst[6:2]; inst[1:0] is always 2'b11 for 32-bit encodings.
  typedef enum logic [4:0] {
    OPC_LOAD    = 5'b00000,
    OPC_MISC    = 5'b00011,
    OPC_OP_IMM  = 5'b00100,
    OPC_AUIPC   = 5'b00101,
    OPC_OP_IMM32 = 5'b00110,
    OPC_STORE   = 5'b01000,
    OPC_OP      = 5'b01100,
    OPC_LUI     = 5'b01101,
    OPC_OP32    = 5'b01110,
    OPC_BRANCH  = 5'b11000,
    OPC_JALR    = 5'b11001,
    OPC_JAL     = 5'b11011,
    OPC_SYSTEM  = 5'b11100
  } opc5_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
  } enc_req_t;

  // True when imm[63:lsb] are all equal, i.e. the value survives truncation to lsb+1 signed bits.
  function automatic logic upper_sext(input logic [63:0] imm, input int unsigned lsb);
    logic [63:0] mask;
    mask = {64{1'b1}} << lsb;
    return ((imm & mask) == 64'd0) || ((imm & mask) == mask);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between the loader and the encoder: request handshake,
// address-load side channel and the output handshake towards instruction memory.
interface inst_encoder_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [63:0]       in_imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_base;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output addr_load, addr_base, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  addr_load, addr_base, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational field packer and immediate range check; zero latency, no handshake.
// An out-of-range immediate still packs its truncated bits; an illegal format packs zero.
module inst_pack
  import inst_enc_pkg::*;
(
  input  enc_req_t    req_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic [63:0] imm;
  assign imm = req_i.imm;

  always_comb begin
    inst_o = '0;
    err_o  = 1'b0;
    case (req_i.fmt)
      FMT_R: inst_o = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      FMT_I: begin
        inst_o = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
        err_o  = !upper_sext(imm, 11);
      end
      FMT_S: begin
        inst_o = {imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, imm[4:0], req_i.opcode};
        err_o  = !upper_sext(imm, 11);
      end
      FMT_B: begin
        inst_o = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                  imm[4:1], imm[11], req_i.opcode};
        err_o  = !upper_sext(imm, 12) || imm[0];
      end
      FMT_U: begin
        inst_o = {imm[31:12], req_i.rd, req_i.opcode};
        err_o  = (imm[11:0] != 12'd0) || !upper_sext(imm, 31);
      end
      FMT_J: begin
        inst_o = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, req_i.opcode};
        err_o  = !upper_sext(imm, 20) || imm[0];
      end
      default: begin
        inst_o = '0;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: packs requests and tags them with a running address; 1-cycle latency.
// Output register plus skid entry; in_ready is registered and drops only when the skid is occupied.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
  input logic          clk,
  input logic          rst_n,
  inst_encoder_if.slave bus
);

  enc_req_t          req;
  logic [31:0]       pk_inst;
  logic              pk_err;

  logic              accept, drain;
  logic [ADDR_W-1:0] tag;

  logic              in_rdy_q, in_rdy_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;
  logic              skid_vld_q, skid_vld_d;
  logic [31:0]       skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              skid_err_q, skid_err_d;

  assign req = '{fmt: bus.in_fmt, opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                 rs2: bus.in_rs2, funct3: bus.in_funct3, funct7: bus.in_funct7, imm: bus.in_imm};

  inst_pack u_pack (
    .req_i  (req),
    .inst_o (pk_inst),
    .err_o  (pk_err)
  );

  always_comb begin
    accept = bus.in_valid && in_rdy_q;
    drain  = out_vld_q && bus.out_ready;
    tag    = bus.addr_load ? bus.addr_base : cnt_q;

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = tag + ADDR_W'(4);
    end else if (bus.addr_load) begin
      cnt_d = bus.addr_base;
    end

    out_vld_d   = out_vld_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_addr_d = skid_addr_q;
    skid_err_d  = skid_err_q;

    // in_ready is low whenever the skid is full, so a skid refill and an accept never coincide.
    if (!out_vld_q || drain) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_inst_d = skid_inst_q;
        out_addr_d = skid_addr_q;
        out_err_d  = skid_err_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_inst_d = pk_inst;
        out_addr_d = tag;
        out_err_d  = pk_err;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_inst_d = pk_inst;
      skid_addr_d = tag;
      skid_err_d  = pk_err;
    end

    in_rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_rdy_q    <= 1'b0;
      cnt_q       <= RST_ADDR;
      out_vld_q   <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= '0;
      skid_addr_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      in_rdy_q    <= in_rdy_d;
      cnt_q       <= cnt_d;
      out_vld_q   <= out_vld_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_addr_q <= skid_addr_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed requests push hand-computed results,
// a negedge monitor pops and compares every transfer and checks stall stability.
module tb_inst_encoder;

  localparam int ADDR_W = 64;

  typedef struct {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_acc = 0;
  logic [ADDR_W-1:0] exp_cnt = '0;
  exp_t sb[$];

  inst_encoder_if #(.ADDR_W(ADDR_W)) ifc ();

  inst_encoder #(.ADDR_W(ADDR_W), .RST_ADDR('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Offer one request (entered at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [63:0] imm,
                      input logic [31:0] einst, input logic eerr,
                      input logic ld, input logic [ADDR_W-1:0] base);
    exp_t e;
    logic [ADDR_W-1:0] t;
    ifc.in_valid = 1'b1; ifc.in_fmt = fmt; ifc.in_opcode = op; ifc.in_rd = rd;
    ifc.in_rs1 = rs1; ifc.in_rs2 = rs2; ifc.in_funct3 = f3; ifc.in_funct7 = f7;
    ifc.in_imm = imm; ifc.addr_load = ld; ifc.addr_base = base;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ld) exp_cnt = base;
      if (ifc.in_ready) begin
        t = exp_cnt;
        exp_cnt = t + 64'd4;
        e.inst = einst; e.addr = t; e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        n_acc++;
        ifc.in_valid = 1'b0; ifc.addr_load = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    flag("accept_timeout");
    ifc.in_valid = 1'b0; ifc.addr_load = 1'b0;
  endtask

  task automatic drain_sb();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) flag("drain_timeout");
  endtask

  // Monitor: pop on every transfer; while stalled, the presented entry must not change.
  logic              stall_prev = 1'b0;
  logic [31:0]       held_inst;
  logic [ADDR_W-1:0] held_addr;
  logic              held_err;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(ifc.out_valid), 64'd1);
        chk("hold_inst", 64'(ifc.out_inst), 64'(held_inst));
        chk("hold_addr", ifc.out_addr, held_addr);
        chk("hold_err", 64'(ifc.out_err), 64'(held_err));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (sb.size() == 0) begin
          flag("unexpected_output");
        end else begin
          e = sb.pop_front();
          chk("out_inst", 64'(ifc.out_inst), 64'(e.inst));
          chk("out_addr", ifc.out_addr, e.addr);
          chk("out_err", 64'(ifc.out_err), 64'(e.err));
        end
      end
      stall_prev = ifc.out_valid && !ifc.out_ready;
      held_inst = ifc.out_inst;
      held_addr = ifc.out_addr;
      held_err = ifc.out_err;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    ifc.in_valid = 1'b0; ifc.in_fmt = '0; ifc.in_opcode = '0; ifc.in_rd = '0;
    ifc.in_rs1 = '0; ifc.in_rs2 = '0; ifc.in_funct3 = '0; ifc.in_funct7 = '0;
    ifc.in_imm = '0; ifc.addr_load = 1'b0; ifc.addr_base = '0; ifc.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_inst", 64'(ifc.out_inst), 64'd0);
    chk("rst_out_addr", ifc.out_addr, 64'd0);
    chk("rst_out_err", 64'(ifc.out_err), 64'd0);
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", 64'(ifc.in_ready), 64'd1);
    @(posedge clk); #1;

    // addi x1,x0,5 with one-cycle latency
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5, 32'h00500093, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("latency_out_valid", 64'(ifc.out_valid), 64'd1);
    @(posedge clk); #1;

    // Back-to-back stream at full rate
    t0 = cyc;
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'd8, 32'h0020A423, 1'b0, 1'b0, '0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd4, 32'hFE000EE3, 1'b0, 1'b0, '0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000, 32'h123452B7, 1'b0, 1'b0, '0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 32'h001000EF, 1'b0, 1'b0, '0);
    chk("stream_cycles", 64'(cyc - t0), 64'd4);
    // R format ignores the immediate entirely
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, '1, 32'h002081B3, 1'b0, 1'b0, '0);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'h8000_0000_0000_0001, 32'h402081B3, 1'b0, 1'b0, '0);

    // Range boundaries and illegal format
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 32'h80000093, 1'b1, 1'b0, '0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2048, 32'h80000093, 1'b0, 1'b0, '0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3, 32'h00000163, 1'b1, 1'b0, '0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h800, 32'h000002B7, 1'b1, 1'b0, '0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h100000, 32'h800000EF, 1'b1, 1'b0, '0);
    send(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 64'd5, 32'h00000000, 1'b1, 1'b0, '0);
    drain_sb();

    // Backpressure: three requests offered while the output is stalled for 5 cycles
    ifc.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 32'h00100093, 1'b0, 1'b0, '0);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2, 32'h00200113, 1'b0, 1'b0, '0);
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3, 32'h00300193, 1'b0, 1'b0, '0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 64'(n_acc), 64'd2);
        chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
        @(posedge clk); #1 ifc.out_ready = 1'b1;
      end
    join
    drain_sb();

    // Address load coincident with an accept, then wrap-around
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5, 32'h00500093, 1'b0, 1'b1, 64'h1000);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2, 32'h00200113, 1'b0, 1'b0, '0);
    ifc.addr_load = 1'b1; ifc.addr_base = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #1 ifc.addr_load = 1'b0;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFC;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 32'h00100093, 1'b0, 1'b0, '0);
    send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3, 32'h00300193, 1'b0, 1'b0, '0);
    drain_sb();

    // Reset with both entries occupied
    ifc.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 32'h00100093, 1'b0, 1'b0, '0);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2, 32'h00200113, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("full_in_ready", 64'(ifc.in_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(ifc.in_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5, 32'h00500093, 1'b0, 1'b0, '0);
    drain_sb();

    repeat (3) @(posedge clk);
    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
